// File: rtl/clock_reset_controller.sv
// Board clock pass-through, stretched system reset, and a burst-mode serial clock
// generator that only starts and stops on whole sclk periods.
module clock_reset_controller #(
  parameter int DIV_WIDTH   = 8,
  parameter int RST_STRETCH = 31,
  parameter bit CPOL        = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 clk_o,
  output logic                 rst_o,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 clk_enable,
  output logic                 sclk_o,
  output logic                 sclk_lead_o,
  output logic                 sclk_trail_o,
  output logic                 active_o
);

  localparam int RCNT_W = (RST_STRETCH > 0) ? $clog2(RST_STRETCH + 1) : 1;
  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RST_STRETCH);

  typedef enum logic {IDLE, RUN} state_t;

  // Power-on values match the reset values so the FPGA comes up held in reset.
  logic              rst_q   = 1'b1;
  logic [RCNT_W-1:0] rcnt    = RCNT_LOAD;
  state_t            state   = IDLE;
  logic [DIV_WIDTH-1:0] cnt  = '0;
  logic [DIV_WIDTH-1:0] div_q;
  logic              sclk_q  = CPOL;
  logic              lead_q  = 1'b0;
  logic              trail_q = 1'b0;
  logic              act_q   = 1'b0;

  assign clk_o        = clk_i;
  assign rst_o        = rst_q;
  assign sclk_o       = sclk_q;
  assign sclk_lead_o  = lead_q;
  assign sclk_trail_o = trail_q;
  assign active_o     = act_q;

  // Reset stretcher
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rst_q <= 1'b1;
      rcnt  <= RCNT_LOAD;
    end else if (rcnt != '0) begin
      rcnt  <= rcnt - 1'b1;
    end else begin
      rst_q <= 1'b0;
    end
  end

  // Serial clock engine; held idle while either raw or stretched reset is high
  always_ff @(posedge clk_i) begin
    if (rst_i || rst_q) begin
      state   <= IDLE;
      cnt     <= '0;
      sclk_q  <= CPOL;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sclk_q  <= CPOL;
          lead_q  <= 1'b0;
          trail_q <= 1'b0;
          if (clk_enable) begin
            state <= RUN;
            cnt   <= '0;
            div_q <= div_i;
            act_q <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == div_q) begin
            cnt    <= '0;
            sclk_q <= ~sclk_q;
            if (sclk_q == CPOL) begin
              lead_q  <= 1'b1;
              trail_q <= 1'b0;
            end else begin
              lead_q  <= 1'b0;
              trail_q <= 1'b1;
              // Enable is only honoured at period end, so bursts never contain runts.
              if (!clk_enable) begin
                state <= IDLE;
                act_q <= 1'b0;
              end
            end
          end else begin
            cnt     <= cnt + 1'b1;
            lead_q  <= 1'b0;
            trail_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_reset_controller.sv
// Directed bench for clock_reset_controller: one CPOL=0 instance with the default
// stretch, and one CPOL=1 instance with a short stretch for the mid-burst reset case.
module tb_clock_reset_controller;

  logic       clk = 1'b0;
  logic       rst_i, clk_enable;
  logic [7:0] div_i;
  logic       clk_o, rst_o, sclk_o, lead, trail, active;

  logic       rst1_i, en1;
  logic [7:0] div1;
  logic       clk_o1, rst_o1, sclk1, lead1, trail1, active1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clock_reset_controller #(.DIV_WIDTH(8), .RST_STRETCH(31), .CPOL(1'b0)) dut (
    .clk_i(clk), .rst_i(rst_i), .clk_o(clk_o), .rst_o(rst_o), .div_i(div_i),
    .clk_enable(clk_enable), .sclk_o(sclk_o), .sclk_lead_o(lead),
    .sclk_trail_o(trail), .active_o(active)
  );

  clock_reset_controller #(.DIV_WIDTH(8), .RST_STRETCH(2), .CPOL(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst1_i), .clk_o(clk_o1), .rst_o(rst_o1), .div_i(div1),
    .clk_enable(en1), .sclk_o(sclk1), .sclk_lead_o(lead1),
    .sclk_trail_o(trail1), .active_o(active1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; clk_enable = 1'b0; div_i = 8'd0;
    rst1_i = 1'b0; en1 = 1'b0; div1 = 8'd0;

    // Power-on values before any clock edge
    #1;
    chk("init_rst_o", rst_o, 1);
    chk("init_sclk", sclk_o, 0);
    chk("init_lead", lead, 0);
    chk("init_trail", trail, 0);
    chk("init_active", active, 0);
    chk("init1_sclk", sclk1, 1);

    // rst_i sampled high at edges 1..3; rst_o must fall at edge 35
    tick(); tick(); tick();
    chk("clk_o_copy", clk_o, clk);
    chk("clk_o1_copy", clk_o1, clk);
    rst_i = 1'b0;
    for (int e = 4; e <= 34; e++) begin
      tick();
      chk("stretch_rst_o", rst_o, 1);
      chk("stretch_sclk", sclk_o, 0);
      chk("stretch_active", active, 0);
    end
    tick();
    chk("release_rst_o", rst_o, 0);

    // Single period, div=3: lead at N+4, trail at N+8
    clk_enable = 1'b1; div_i = 8'd3;
    tick();
    chk("sp_start_active", active, 1);
    chk("sp_start_sclk", sclk_o, 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("sp_sclk", sclk_o, (k >= 4 && k < 8));
      chk("sp_lead", lead, (k == 4));
      chk("sp_trail", trail, (k == 8));
      chk("sp_active", active, (k < 8));
      if (k == 1) clk_enable = 1'b0;
    end

    // Divide-by-2 continuous for 20 cycles
    div_i = 8'd0; clk_enable = 1'b1;
    tick();
    chk("d2_start_active", active, 1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("d2_sclk", sclk_o, k % 2);
      chk("d2_lead", lead, k % 2);
      chk("d2_trail", trail, (k % 2) == 0);
      chk("d2_active", active, 1);
    end
    clk_enable = 1'b0;
    tick();
    chk("d2_last_lead", lead, 1);
    chk("d2_last_active", active, 1);
    tick();
    chk("d2_stop_trail", trail, 1);
    chk("d2_stop_active", active, 0);
    chk("d2_stop_sclk", sclk_o, 0);
    tick();
    chk("d2_idle_trail", trail, 0);

    // div=2 latched; change to 7 mid-burst is ignored until the next burst
    div_i = 8'd2; clk_enable = 1'b1;
    tick();
    chk("dc_start_active", active, 1);
    div_i = 8'd7;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("dc_sclk", sclk_o, (k >= 3 && k < 6) || (k >= 9 && k < 12));
      chk("dc_lead", lead, (k == 3 || k == 9));
      chk("dc_active", active, (k < 12));
      if (k == 7) clk_enable = 1'b0;
    end
    clk_enable = 1'b1;
    tick();
    chk("dc2_start_active", active, 1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("dc2_sclk", sclk_o, (k >= 8 && k < 16));
      chk("dc2_lead", lead, (k == 8));
      chk("dc2_trail", trail, (k == 16));
      chk("dc2_active", active, (k < 16));
      if (k == 1) clk_enable = 1'b0;
    end

    // Back-to-back bursts, div=1: two periods, then IDLE gap, then a new burst
    div_i = 8'd1; clk_enable = 1'b1;
    tick();
    chk("bb_start_active", active, 1);
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("bb_sclk", sclk_o, (k >= 2 && k < 4) || (k >= 6 && k < 8) || (k >= 11 && k < 13));
      chk("bb_lead", lead, (k == 2 || k == 6 || k == 11));
      chk("bb_trail", trail, (k == 4 || k == 8 || k == 13));
      chk("bb_active", active, (k < 8) || (k >= 9 && k < 13));
      if (k == 5) clk_enable = 1'b0;
      if (k == 8) clk_enable = 1'b1;
      if (k == 11) clk_enable = 1'b0;
    end

    // CPOL=1 instance, div=5: reset while sclk is low
    en1 = 1'b1; div1 = 8'd5;
    tick();
    chk("rm_start_active", active1, 1);
    chk("rm_start_sclk", sclk1, 1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("rm_sclk", sclk1, (k >= 6) ? 0 : 1);
      chk("rm_lead", lead1, (k == 6));
    end
    rst1_i = 1'b1;
    tick();
    chk("rm_rst_sclk", sclk1, 1);
    chk("rm_rst_active", active1, 0);
    chk("rm_rst_lead", lead1, 0);
    chk("rm_rst_trail", trail1, 0);
    chk("rm_rst_o", rst_o1, 1);
    rst1_i = 1'b0; en1 = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk("rm_hold_rst_o", rst_o1, 1);
      chk("rm_hold_active", active1, 0);
      chk("rm_hold_sclk", sclk1, 1);
    end
    tick();
    chk("rm_release_rst_o", rst_o1, 0);
    chk("rm_release_active", active1, 0);
    tick();
    chk("rm_idle_active", active1, 0);
    en1 = 1'b1;
    tick();
    chk("rm_restart_active", active1, 1);
    chk("rm_restart_sclk", sclk1, 1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("rm2_sclk", sclk1, (k == 6) ? 0 : 1);
      chk("rm2_lead", lead1, (k == 6));
    end
    en1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
